cayde_fetch: RTL and testbench

- Instruction-fetch stage for the cayde RISC-V core; sits directly upstream of the decoder and drives its 32-bit instruction input.
- Owns the PC, issues in-order word requests to instruction memory and buffers responses in a small FIFO.
- Presents {instr, pc, err} to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing the FIFO and discarding in-flight responses.

---
 rtl/cayde_fetch.sv | 127 ++++++++++++
 tb/tb_cayde_fetch.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cayde_fetch.sv
// cayde instruction-fetch stage: PC, imem request credit,
// response FIFO and redirect-time drop of stale responses.
module cayde_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic        imem_req_valid_out,
  input  logic        imem_req_ready_in,
  output logic [31:0] imem_req_addr_out,
  input  logic        imem_rsp_valid_in,
  input  logic [31:0] imem_rsp_data_in,
  input  logic        imem_rsp_err_in,
  input  logic        redirect_valid_in,
  input  logic [31:0] redirect_pc_in,
  output logic        instr_valid_out,
  input  logic        instr_ready_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        fetch_err_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        head;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic          live_q;
  logic [CW:0]   used;
  logic [31:0]   tgt;
  logic          fire, push, pop, head_v;

  // outstanding counts dropped responses too, so credit covers them
  assign used = {1'b0, cnt_q} + {1'b0, out_q};
  assign tgt  = redirect_pc_in & 32'hFFFF_FFFC;

  assign imem_req_valid_out = live_q && !rst_in &&
                              !redirect_valid_in && (used < CAP);
  assign imem_req_addr_out  = pc_q;

  assign fire   = imem_req_valid_out && imem_req_ready_in;
  assign head_v = (cnt_q != '0) && !rst_in;
  assign push   = imem_rsp_valid_in && (drop_q == '0) &&
                  !redirect_valid_in;
  assign pop    = head_v && instr_ready_in && !redirect_valid_in;
  assign head   = mem_q[rd_q];

  assign instr_valid_out = head_v;
  assign instr_out       = head_v ? head.instr : '0;
  assign pc_out          = head_v ? head.pc    : '0;
  assign fetch_err_out   = head_v ? head.err   : 1'b0;

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    out_d    = out_q + CW'(fire) - CW'(imem_rsp_valid_in);
    if (redirect_valid_in) begin
      pc_d     = tgt;
      rsp_pc_d = tgt;
      cnt_d    = '0;
      wr_d     = '0;
      rd_d     = '0;
      drop_d   = out_q - CW'(imem_rsp_valid_in);
    end else begin
      if (fire)
        pc_d = pc_q + 32'd4;
      if (imem_rsp_valid_in && (drop_q != '0))
        drop_d = drop_q - CW'(1);
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_d     = wr_q + AW'(1);
      end
      if (pop)
        rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      cnt_q    <= '0;
      out_q    <= '0;
      drop_q   <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      live_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      live_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push && !rst_in)
      mem_q[wr_q] <= '{instr: imem_rsp_data_in,
                       pc:    rsp_pc_q,
                       err:   imem_rsp_err_in};
  end

endmodule

// File: tb/tb_cayde_fetch.sv
// Directed bench for cayde_fetch with an in-order
// fixed-latency instruction memory model.
module tb_cayde_fetch;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        imem_req_valid_out;
  logic        imem_req_ready_in;
  logic [31:0] imem_req_addr_out;
  logic        imem_rsp_valid_in;
  logic [31:0] imem_rsp_data_in;
  logic        imem_rsp_err_in;
  logic        redirect_valid_in;
  logic [31:0] redirect_pc_in;
  logic        instr_valid_out;
  logic        instr_ready_in;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        fetch_err_out;

  cayde_fetch #(.RESET_PC(RPC), .DEPTH(2)) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .imem_req_valid_out (imem_req_valid_out),
    .imem_req_ready_in  (imem_req_ready_in),
    .imem_req_addr_out  (imem_req_addr_out),
    .imem_rsp_valid_in  (imem_rsp_valid_in),
    .imem_rsp_data_in   (imem_rsp_data_in),
    .imem_rsp_err_in    (imem_rsp_err_in),
    .redirect_valid_in  (redirect_valid_in),
    .redirect_pc_in     (redirect_pc_in),
    .instr_valid_out    (instr_valid_out),
    .instr_ready_in     (instr_ready_in),
    .instr_out          (instr_out),
    .pc_out             (pc_out),
    .fetch_err_out      (fetch_err_out)
  );

  always #5 clk_in = ~clk_in;

  int          vec = 0;
  int          miss = 0;
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] err_addr = 32'h1;
  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] req_log[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_ins[$];
  logic        pop_err[$];

  function automatic logic [31:0] fdata(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic drive_rsp();
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      imem_rsp_valid_in = 1'b1;
      imem_rsp_data_in  = fdata(q_addr[0]);
      imem_rsp_err_in   = (q_addr[0] == err_addr);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      imem_rsp_valid_in = 1'b0;
      imem_rsp_data_in  = '0;
      imem_rsp_err_in   = 1'b0;
    end
  endtask

  // entered at a negedge; leaves at the next negedge
  task automatic step();
    #1;
    if (imem_req_valid_out && imem_req_ready_in) begin
      q_addr.push_back(imem_req_addr_out);
      q_due.push_back(cyc + lat);
      req_log.push_back(imem_req_addr_out);
    end
    if (instr_valid_out && instr_ready_in && !redirect_valid_in) begin
      pop_pc.push_back(pc_out);
      pop_ins.push_back(instr_out);
      pop_err.push_back(fetch_err_out);
    end
    if (rst_in) begin
      q_addr.delete();
      q_due.delete();
    end
    @(posedge clk_in);
    @(negedge clk_in);
    cyc++;
    drive_rsp();
  endtask

  task automatic clear_logs();
    req_log.delete();
    pop_pc.delete();
    pop_ins.delete();
    pop_err.delete();
  endtask

  task automatic do_reset(input int l);
    lat = l;
    rst_in = 1'b1;
    redirect_valid_in = 1'b0;
    imem_req_ready_in = 1'b1;
    instr_ready_in = 1'b1;
    step();
    step();
    rst_in = 1'b0;
    clear_logs();
  endtask

  task automatic run_pops(input int n, output bit to);
    int b;
    b = 60;
    while (pop_pc.size() < n && b > 0) begin
      step();
      b--;
    end
    to = (pop_pc.size() < n);
  endtask

  task automatic test_reset();
    lat = 1;
    rst_in = 1'b1;
    redirect_valid_in = 1'b0;
    redirect_pc_in = '0;
    imem_req_ready_in = 1'b1;
    instr_ready_in = 1'b1;
    step();
    step();
    #1;
    vec++;
    if (imem_req_valid_out !== 1'b0 || instr_valid_out !== 1'b0) begin
      miss++;
      $display("FAIL rst_valids: req %b instr %b want 0 0",
               imem_req_valid_out, instr_valid_out);
    end
    rst_in = 1'b0;
    #1;
    vec++;
    if (imem_req_valid_out !== 1'b0 || instr_valid_out !== 1'b0) begin
      miss++;
      $display("FAIL post_rst_valids: req %b instr %b want 0 0",
               imem_req_valid_out, instr_valid_out);
    end
    vec++;
    if (instr_out !== '0 || pc_out !== '0 || fetch_err_out !== 1'b0) begin
      miss++;
      $display("FAIL empty_outs: instr %h pc %h err %b want 0 0 0",
               instr_out, pc_out, fetch_err_out);
    end
    clear_logs();
    step();
    vec++;
    if (imem_req_valid_out !== 1'b1 || imem_req_addr_out !== RPC) begin
      miss++;
      $display("FAIL first_req: valid %b addr %h want 1 %h",
               imem_req_valid_out, imem_req_addr_out, RPC);
    end
  endtask

  task automatic test_stream();
    bit to;
    do_reset(1);
    run_pops(4, to);
    vec++;
    if (to) begin
      miss++;
      $display("FAIL stream_timeout: pops %0d want 4", pop_pc.size());
    end
    for (int i = 0; i < 4; i++) begin
      vec++;
      if (req_log[i] !== RPC + 32'(4 * i)) begin
        miss++;
        $display("FAIL stream_req%0d: got %h want %h",
                 i, req_log[i], RPC + 32'(4 * i));
      end
      vec++;
      if (pop_pc[i] !== RPC + 32'(4 * i) ||
          pop_ins[i] !== fdata(RPC + 32'(4 * i))) begin
        miss++;
        $display("FAIL stream_pop%0d: pc %h instr %h want %h %h",
                 i, pop_pc[i], pop_ins[i], RPC + 32'(4 * i),
                 fdata(RPC + 32'(4 * i)));
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    do_reset(1);
    instr_ready_in = 1'b0;
    for (int i = 0; i < 6; i++) step();
    #1;
    vec++;
    if (req_log.size() != 2 || imem_req_valid_out !== 1'b0) begin
      miss++;
      $display("FAIL bp_credit: reqs %0d valid %b want 2 0",
               req_log.size(), imem_req_valid_out);
    end
    vec++;
    if (instr_valid_out !== 1'b1 || pc_out !== RPC ||
        instr_out !== fdata(RPC)) begin
      miss++;
      $display("FAIL bp_head: v %b pc %h instr %h want 1 %h %h",
               instr_valid_out, pc_out, instr_out, RPC, fdata(RPC));
    end
    instr_ready_in = 1'b1;
    run_pops(3, to);
    vec++;
    if (to || pop_pc[0] !== RPC || pop_pc[1] !== RPC + 32'd4 ||
        pop_pc[2] !== RPC + 32'd8) begin
      miss++;
      $display("FAIL bp_drain: pcs %h %h %h want %h %h %h",
               pop_pc[0], pop_pc[1], pop_pc[2],
               RPC, RPC + 32'd4, RPC + 32'd8);
    end
    vec++;
    if (req_log[2] !== RPC + 32'd8) begin
      miss++;
      $display("FAIL bp_resume: got %h want %h", req_log[2], RPC + 32'd8);
    end
  endtask

  task automatic test_req_stall();
    do_reset(1);
    imem_req_ready_in = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      vec++;
      if (imem_req_valid_out !== 1'b1 || imem_req_addr_out !== RPC) begin
        miss++;
        $display("FAIL stall_hold%0d: valid %b addr %h want 1 %h",
                 i, imem_req_valid_out, imem_req_addr_out, RPC);
      end
      step();
    end
    imem_req_ready_in = 1'b1;
    step();
    #1;
    vec++;
    if (req_log.size() != 1 || req_log[0] !== RPC ||
        imem_req_addr_out !== RPC + 32'd4) begin
      miss++;
      $display("FAIL stall_accept: reqs %0d addr %h want 1 %h",
               req_log.size(), imem_req_addr_out, RPC + 32'd4);
    end
  endtask

  task automatic test_redirect_drop();
    bit to;
    do_reset(3);
    step();
    step();
    step();
    #1;
    vec++;
    if (imem_req_valid_out !== 1'b0 || req_log.size() != 2) begin
      miss++;
      $display("FAIL rd_full: valid %b reqs %0d want 0 2",
               imem_req_valid_out, req_log.size());
    end
    redirect_valid_in = 1'b1;
    redirect_pc_in = 32'h0000_2002;
    step();
    redirect_valid_in = 1'b0;
    clear_logs();
    run_pops(1, to);
    vec++;
    if (to || req_log[0] !== 32'h2000) begin
      miss++;
      $display("FAIL rd_next_addr: got %h want %h", req_log[0], 32'h2000);
    end
    vec++;
    if (pop_pc[0] !== 32'h2000 || pop_ins[0] !== fdata(32'h2000)) begin
      miss++;
      $display("FAIL rd_first_pop: pc %h instr %h want %h %h",
               pop_pc[0], pop_ins[0], 32'h2000, fdata(32'h2000));
    end
  endtask

  task automatic test_redirect_collide();
    bit to;
    do_reset(1);
    step();
    step();
    step();
    vec++;
    if (instr_valid_out !== 1'b1 || pc_out !== RPC) begin
      miss++;
      $display("FAIL col_pre: v %b pc %h want 1 %h",
               instr_valid_out, pc_out, RPC);
    end
    redirect_valid_in = 1'b1;
    redirect_pc_in = 32'h0000_3000;
    #1;
    vec++;
    if (imem_req_valid_out !== 1'b0) begin
      miss++;
      $display("FAIL col_noreq: valid %b want 0", imem_req_valid_out);
    end
    step();
    redirect_valid_in = 1'b0;
    clear_logs();
    #1;
    vec++;
    if (instr_valid_out !== 1'b0 || pc_out !== '0) begin
      miss++;
      $display("FAIL col_flush: v %b pc %h want 0 0",
               instr_valid_out, pc_out);
    end
    vec++;
    if (imem_req_valid_out !== 1'b1 || imem_req_addr_out !== 32'h3000) begin
      miss++;
      $display("FAIL col_resume: valid %b addr %h want 1 %h",
               imem_req_valid_out, imem_req_addr_out, 32'h3000);
    end
    run_pops(1, to);
    vec++;
    if (to || pop_pc[0] !== 32'h3000 || pop_ins[0] !== fdata(32'h3000)) begin
      miss++;
      $display("FAIL col_pop: pc %h instr %h want %h %h",
               pop_pc[0], pop_ins[0], 32'h3000, fdata(32'h3000));
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    do_reset(3);
    step();
    step();
    step();
    redirect_valid_in = 1'b1;
    redirect_pc_in = 32'h0000_3000;
    step();
    redirect_pc_in = 32'h0000_4004;
    step();
    redirect_valid_in = 1'b0;
    clear_logs();
    run_pops(2, to);
    vec++;
    if (to || req_log[0] !== 32'h4004) begin
      miss++;
      $display("FAIL b2b_addr: got %h want %h", req_log[0], 32'h4004);
    end
    vec++;
    if (pop_pc[0] !== 32'h4004 || pop_ins[0] !== fdata(32'h4004) ||
        pop_pc[1] !== 32'h4008) begin
      miss++;
      $display("FAIL b2b_pop: pc %h instr %h pc1 %h want %h %h %h",
               pop_pc[0], pop_ins[0], pop_pc[1],
               32'h4004, fdata(32'h4004), 32'h4008);
    end
  endtask

  task automatic test_wrap_err();
    bit to;
    do_reset(1);
    err_addr = 32'h104;
    run_pops(3, to);
    vec++;
    if (to) begin
      miss++;
      $display("FAIL err_timeout: pops %0d want 3", pop_pc.size());
    end
    for (int i = 0; i < 3; i++) begin
      vec++;
      if (pop_pc[i] !== RPC + 32'(4 * i) || pop_err[i] !== (i == 1)) begin
        miss++;
        $display("FAIL err_pop%0d: pc %h err %b want %h %b",
                 i, pop_pc[i], pop_err[i], RPC + 32'(4 * i), i == 1);
      end
    end
    err_addr = 32'h1;
    redirect_valid_in = 1'b1;
    redirect_pc_in = 32'hFFFF_FFFC;
    step();
    redirect_valid_in = 1'b0;
    clear_logs();
    run_pops(2, to);
    vec++;
    if (to || req_log[0] !== 32'hFFFF_FFFC || req_log[1] !== 32'h0) begin
      miss++;
      $display("FAIL wrap_req: got %h %h want %h %h",
               req_log[0], req_log[1], 32'hFFFF_FFFC, 32'h0);
    end
    vec++;
    if (pop_pc[0] !== 32'hFFFF_FFFC || pop_pc[1] !== 32'h0 ||
        pop_ins[1] !== fdata(32'h0)) begin
      miss++;
      $display("FAIL wrap_pop: pcs %h %h instr %h want %h %h %h",
               pop_pc[0], pop_pc[1], pop_ins[1],
               32'hFFFF_FFFC, 32'h0, fdata(32'h0));
    end
  endtask

  initial begin
    imem_rsp_valid_in = 1'b0;
    imem_rsp_data_in = '0;
    imem_rsp_err_in = 1'b0;
    @(negedge clk_in);
    test_reset();
    test_stream();
    test_backpressure();
    test_req_stall();
    test_redirect_drop();
    test_redirect_collide();
    test_back_to_back();
    test_wrap_err();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active, want finish");
    $fatal(1);
  end

endmodule
